// File: rtl/tl_line_master_if.sv
// TileLink-UH A/D channel bundle between a line master and a memory-side slave.
interface tl_line_master_if;
  logic [2:0]   a_opcode;
  logic [2:0]   a_param;
  logic [7:0]   a_size;
  logic [2:0]   a_source;
  logic [31:0]  a_address;
  logic [15:0]  a_mask;
  logic [127:0] a_data;
  logic         a_corrupt;
  logic         a_valid;
  logic         a_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [7:0]   d_size;
  logic [2:0]   d_source;
  logic [2:0]   d_sink;
  logic         d_denied;
  logic [127:0] d_data;
  logic         d_corrupt;
  logic         d_valid;
  logic         d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tl_line_master.sv
// TileLink-UH line master: one cache-line request -> Get or PutFullData burst, D beats reassembled.
// Optional D-channel watchdog enabled by defining TL_MST_TIMEOUT_EN.
module tl_line_master #(
  parameter int LINE_SZ   = 6,
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 1024,
  localparam int BEATS    = 1 << (LINE_SZ - 4),
  localparam int LW       = 8 * (1 << LINE_SZ)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_wr,
  input  logic [31:0]   i_req_addr,
  input  logic [LW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [LW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  tl_line_master_if.master mst
);

  localparam int CW = (LINE_SZ > 4) ? (LINE_SZ - 4) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A_GET  = 3'd1;
  localparam logic [2:0] S_A_PUT  = 3'd2;
  localparam logic [2:0] S_D_WAIT = 3'd3;
  localparam logic [2:0] S_RSP    = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic          r_wr;
  logic [LW-1:0] r_wdata;
  logic [LW-1:0] r_rdata;
  logic          r_err;

  logic          w_a_fire;
  logic          w_d_fire;
  logic          w_d_bad;
  logic [2:0]    w_d_exp_op;
  logic [127:0]  w_a_beat;
  logic          w_tmo_hit;
  logic          w_unused_bits;

  assign w_a_fire   = mst.a_valid & mst.a_ready;
  assign w_d_fire   = mst.d_valid & mst.d_ready;
  assign w_d_exp_op = r_wr ? 3'd0 : 3'd1;
  assign w_d_bad    = mst.d_denied | mst.d_corrupt | (mst.d_opcode != w_d_exp_op);
  assign w_a_beat   = 128'(r_wdata >> {r_cnt, 7'd0});
  assign w_unused_bits = ^{mst.d_param, mst.d_size, mst.d_source, mst.d_sink,
                           i_req_addr[LINE_SZ-1:0]};

  // Every output decodes from state or latched registers; nothing from req_* reaches the A channel.
  assign o_req_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = (r_state == S_RSP);
  assign o_rsp_err     = r_err;
  assign o_rsp_rdata   = r_rdata;
  assign mst.a_valid   = (r_state == S_A_GET) | (r_state == S_A_PUT);
  assign mst.a_opcode  = r_wr ? 3'd0 : 3'd4;
  assign mst.a_param   = 3'd0;
  assign mst.a_size    = 8'(LINE_SZ);
  assign mst.a_source  = 3'(SOURCE_ID);
  assign mst.a_address = r_addr;
  assign mst.a_mask    = 16'hFFFF;
  assign mst.a_data    = (r_state == S_A_PUT) ? w_a_beat : 128'd0;
  assign mst.a_corrupt = 1'b0;
  assign mst.d_ready   = (r_state == S_D_WAIT);

`ifdef TL_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;

  // Watchdog restarts on entry to D_WAIT and on every accepted D beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= TW'(0);
    end else if ((r_state != S_D_WAIT) || w_d_fire) begin
      r_tmo <= TW'(0);
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_D_WAIT) && (r_tmo == TW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Transaction FSM with latched request, beat counter and line reassembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= 32'd0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_addr  <= {i_req_addr[31:LINE_SZ], {LINE_SZ{1'b0}}};
            r_wr    <= i_req_wr;
            r_wdata <= i_req_wdata;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_state <= i_req_wr ? S_A_PUT : S_A_GET;
          end
        end
        S_A_GET: begin
          if (w_a_fire) begin
            r_state <= S_D_WAIT;
          end
        end
        S_A_PUT: begin
          if (w_a_fire) begin
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= S_D_WAIT;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
        S_D_WAIT: begin
          if (w_d_fire) begin
            if (w_d_bad) begin
              r_err <= 1'b1;
            end
            if (!r_wr) begin
              for (int k = 0; k < BEATS; k++) begin
                if (r_cnt == CW'(k)) begin
                  r_rdata[128*k +: 128] <= mst.d_data;
                end
              end
              if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_state <= S_RSP;
              end else begin
                r_cnt <= r_cnt + ONE;
              end
            end else begin
              r_state <= S_RSP;
            end
          end else if (w_tmo_hit) begin
            // Abandon the burst: leftover D beats are never accepted.
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_line_master.sv
// Directed, table-driven bench for tl_line_master with a small in-bench TileLink memory slave.
module tb_tl_line_master;
  localparam int LINE_SZ = 6;
  localparam int BEATS   = 4;
  localparam int LW      = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [31:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [LW-1:0] rsp_rdata;

  tl_line_master_if bus ();

  tl_line_master #(.LINE_SZ(LINE_SZ), .SOURCE_ID(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .mst(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   exp_addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp_rdata;
    logic          chk_rd;
    int            bad_beat;
    int            bad_kind;   // 1 denied, 2 corrupt, 3 wrong opcode
    logic          toggle;
    int            hold;
    logic          no_resp;
    logic          exp_err;
    int            exp_lat;    // negedge index of first rsp_valid, 0 = unchecked
  } vec_t;

  typedef struct {
    logic [2:0]   op;
    logic [127:0] data;
    logic         den;
    logic         cor;
  } dbeat_t;

  logic [127:0] mem [256];
  int n_err = 0;
  int n_checks = 0;
  vec_t vecs[$];

  function automatic logic [127:0] pre(input int r);
    logic [31:0] w;
    w = 32'hD00D_0000 | 32'(r);
    return {4{w}};
  endfunction

  function automatic logic [LW-1:0] line4(input logic [127:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, exp_addr,
                              input logic [LW-1:0] wdata, exp_rdata, input logic chk_rd,
                              input int bad_beat, bad_kind, input logic toggle, input int hold,
                              input logic no_resp, exp_err, input int exp_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.exp_addr = exp_addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.chk_rd = chk_rd; v.bad_beat = bad_beat; v.bad_kind = bad_kind;
    v.toggle = toggle; v.hold = hold; v.no_resp = no_resp; v.exp_err = exp_err;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    dbeat_t q[$];
    dbeat_t b;
    int n, a_beats, put_idx, rsp_cnt, rsp_n, row;
    logic done, busy_bad;
    a_beats = 0; put_idx = 0; rsp_cnt = 0; rsp_n = 0; done = 1'b0; busy_bad = 1'b0;
    row = int'(v.exp_addr[11:4]);
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", idx), LW'(req_ready), LW'(1'b1));
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = '0;
    n = 1;
    while (!done && n < 200) begin
      if (q.size() > 0) begin
        bus.d_valid = 1'b1; bus.d_opcode = q[0].op; bus.d_data = q[0].data;
        bus.d_denied = q[0].den; bus.d_corrupt = q[0].cor;
        if (bus.d_ready) void'(q.pop_front());
      end else begin
        bus.d_valid = 1'b0; bus.d_denied = 1'b0; bus.d_corrupt = 1'b0;
      end
      bus.a_ready = v.toggle ? ((n % 2) == 1) : 1'b1;
      if (bus.a_valid && bus.a_ready) begin
        a_beats++;
        chk($sformatf("v%0d a_opcode", idx), LW'(bus.a_opcode), v.wr ? LW'(0) : LW'(4));
        chk($sformatf("v%0d a_address", idx), LW'(bus.a_address), LW'(v.exp_addr));
        chk($sformatf("v%0d a_size_src_mask", idx),
            LW'({bus.a_size, bus.a_source, bus.a_mask, bus.a_param, bus.a_corrupt}),
            LW'({8'd6, 3'd5, 16'hFFFF, 3'd0, 1'b0}));
        if (v.wr) begin
          if (put_idx < BEATS) begin
            chk($sformatf("v%0d put_beat%0d", idx, put_idx), LW'(bus.a_data),
                LW'(v.wdata[128*put_idx +: 128]));
            mem[(row + put_idx) & 255] = bus.a_data;
          end
          put_idx++;
          if (put_idx == BEATS && !v.no_resp) begin
            b.op = (v.bad_kind == 3 && v.bad_beat == 0) ? 3'd1 : 3'd0;
            b.data = 128'd0;
            b.den = (v.bad_kind == 1 && v.bad_beat == 0);
            b.cor = (v.bad_kind == 2 && v.bad_beat == 0);
            q.push_back(b);
          end
        end else begin
          chk($sformatf("v%0d get_data_zero", idx), LW'(bus.a_data), LW'(0));
          for (int k = 0; k < BEATS && !v.no_resp; k++) begin
            b.op = (v.bad_kind == 3 && v.bad_beat == k) ? 3'd0 : 3'd1;
            b.data = mem[(row + k) & 255];
            b.den = (v.bad_kind == 1 && v.bad_beat == k);
            b.cor = (v.bad_kind == 2 && v.bad_beat == k);
            q.push_back(b);
          end
        end
      end
      if (req_ready) busy_bad = 1'b1;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_n == 0) rsp_n = n;
        if (rsp_cnt > v.hold) begin
          rsp_ready = 1'b1;
          done = 1'b1;
          chk($sformatf("v%0d rsp_err", idx), LW'(rsp_err), LW'(v.exp_err));
          if (v.chk_rd) chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        end else begin
          rsp_ready = 1'b0;
        end
      end else begin
        rsp_ready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0; bus.a_ready = 1'b0; bus.d_valid = 1'b0;
    bus.d_denied = 1'b0; bus.d_corrupt = 1'b0;
    chk($sformatf("v%0d completed_in_budget", idx), LW'(done), LW'(1'b1));
    chk($sformatf("v%0d post_rsp_valid", idx), LW'(rsp_valid), LW'(1'b0));
    chk($sformatf("v%0d post_req_ready", idx), LW'(req_ready), LW'(1'b1));
    chk($sformatf("v%0d rsp_valid_cycles", idx), LW'(rsp_cnt), LW'(v.hold + 1));
    chk($sformatf("v%0d a_beats", idx), LW'(a_beats), v.wr ? LW'(BEATS) : LW'(1));
    chk($sformatf("v%0d req_ready_busy", idx), LW'(busy_bad), LW'(1'b0));
    chk($sformatf("v%0d d_beats_left", idx), LW'(q.size()), LW'(0));
    if (v.exp_lat != 0) chk($sformatf("v%0d latency", idx), LW'(rsp_n), LW'(v.exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] pat_t, pat_e;
    for (int r = 0; r < 256; r++) mem[r] = pre(r);
    pat_t = line4(128'hFEDC_BA98_7654_3210_0000_0000_0000_00A0, 128'h0000_0000_0000_0000_1111_2222_3333_00A1,
                  128'h8000_0000_0000_0001_8000_0000_0000_00A2, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_00A3);
    pat_e = line4(128'd5, 128'd6, 128'd7, 128'd8);
    vecs.push_back(mk(1'b0, 32'h8000_0040, 32'h8000_0040, '0, line4(pre(4), pre(5), pre(6), pre(7)),
                      1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b0, 6));
    vecs.push_back(mk(1'b1, 32'h8000_0080, 32'h8000_0080, line4(128'd1, 128'd2, 128'd3, 128'd4), '0,
                      1'b0, -1, 0, 1'b0, 0, 1'b0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h8000_009C, 32'h8000_0080, '0, line4(128'd1, 128'd2, 128'd3, 128'd4),
                      1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b0, 6));
    vecs.push_back(mk(1'b1, 32'h8000_00C0, 32'h8000_00C0, pat_t, '0,
                      1'b0, -1, 0, 1'b1, 5, 1'b0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h8000_00C0, 32'h8000_00C0, '0, pat_t,
                      1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h8000_0040, 32'h8000_0040, '0, line4(pre(4), pre(5), pre(6), pre(7)),
                      1'b1, 2, 1, 1'b0, 0, 1'b0, 1'b1, 6));
    vecs.push_back(mk(1'b0, 32'h8000_0040, 32'h8000_0040, '0, '0, 1'b0, 0, 2, 1'b0, 0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h8000_0040, 32'h8000_0040, '0, '0, 1'b0, 3, 3, 1'b0, 0, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b1, 32'h8000_0100, 32'h8000_0100, pat_e, '0, 1'b0, 0, 1, 1'b0, 1, 1'b0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h8000_0100, 32'h8000_0100, '0, pat_e, 1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b0, 0));
`ifdef TL_MST_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 32'h8000_0040, 32'h8000_0040, '0, '0, 1'b0, -1, 0, 1'b0, 0, 1'b1, 1'b1, 18));
    vecs.push_back(mk(1'b0, 32'h8000_0080, 32'h8000_0080, '0, line4(128'd1, 128'd2, 128'd3, 128'd4),
                      1'b1, -1, 0, 1'b0, 0, 1'b0, 1'b0, 6));
`endif

    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h8000_0040; req_wdata = '1;
    rsp_ready = 1'b0;
    bus.a_ready = 1'b1; bus.d_valid = 1'b1; bus.d_opcode = 3'd1; bus.d_param = 2'd0;
    bus.d_size = 8'd6; bus.d_source = 3'd0; bus.d_sink = 3'd0; bus.d_denied = 1'b0;
    bus.d_data = 128'd0; bus.d_corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", LW'(req_ready), LW'(1'b1));
    chk("reset a_valid", LW'(bus.a_valid), LW'(1'b0));
    chk("reset d_ready", LW'(bus.d_ready), LW'(1'b0));
    chk("reset rsp_valid", LW'(rsp_valid), LW'(1'b0));
    chk("reset rsp_err", LW'(rsp_err), LW'(1'b0));
    chk("reset rsp_rdata", rsp_rdata, '0);
    req_valid = 1'b0; bus.a_ready = 1'b0; bus.d_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
